// File: rtl/gen_gamma_pkg.sv
// Shared types and helpers for the pipelined gamma decoder subtractor.
package gen_gamma_pkg;

    typedef struct packed {
        logic carry;
        logic borrow;
    } sub_flags_t;

    // ceil((width+1)/chunk): A is one bit wider than the result
    function automatic int stages_f(input int width, input int chunk);
        return (width + chunk) / chunk;
    endfunction

endpackage

// File: rtl/gamma_sub_stage.sv
// One CHUNK-bit slice of the pipelined subtractor with its borrow,
// operand, partial-result and tag registers plus elastic handshake.
module gamma_sub_stage
    import gen_gamma_pkg::*;
#(
    parameter int W1    = 9,
    parameter int CHUNK = 4,
    parameter int K     = 0,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W1-1:0]    in_a,
    input  logic [W1-1:0]    in_b,
    input  logic [W1-1:0]    in_d,
    input  logic             in_bo,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W1-1:0]    out_a,
    output logic [W1-1:0]    out_b,
    output logic [W1-1:0]    out_d,
    output logic             out_bo,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LO = K * CHUNK;
    // the top slice may be narrower than CHUNK
    localparam int SW = ((W1 - LO) < CHUNK) ? (W1 - LO) : CHUNK;

    logic [SW:0]       w_sub;
    logic [W1-1:0]     w_d;

    logic              r_valid;
    logic [W1-1:0]     r_a;
    logic [W1-1:0]     r_b;
    logic [W1-1:0]     r_d;
    logic              r_bo;
    logic [TAG_W-1:0]  r_tag;

    assign w_sub = {1'b0, in_a[LO +: SW]}
                 - {1'b0, in_b[LO +: SW]}
                 - {{SW{1'b0}}, in_bo};

    always_comb begin
        w_d           = in_d;
        w_d[LO +: SW] = w_sub[SW-1:0];
    end

    assign in_ready = !r_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_bo    <= 1'b0;
            r_tag   <= '0;
        end else if (in_ready) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_a   <= in_a;
                r_b   <= in_b;
                r_d   <= w_d;
                r_bo  <= w_sub[SW];
                r_tag <= in_tag;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_a     = r_a;
    assign out_b     = r_b;
    assign out_d     = r_d;
    assign out_bo    = r_bo;
    assign out_tag   = r_tag;

endmodule

// File: rtl/gamma_sub_pipe.sv
// Pipelined A - B for the gamma decoder, one CHUNK slice per stage.
// Define SUB_SATURATE_EN to clamp out_diff on borrow/overflow.
module gamma_sub_pipe
    import gen_gamma_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_carry,
    output logic             out_borrow,
    output logic [TAG_W-1:0] out_tag
);

    localparam int W1     = WIDTH + 1;
    localparam int STAGES = stages_f(WIDTH, CHUNK);

    logic             w_valid [STAGES+1];
    logic             w_ready [STAGES+1];
    logic [W1-1:0]    w_a     [STAGES+1];
    logic [W1-1:0]    w_b     [STAGES+1];
    logic [W1-1:0]    w_d     [STAGES+1];
    logic             w_bo    [STAGES+1];
    logic [TAG_W-1:0] w_tag   [STAGES+1];
    logic             w_unused;
    sub_flags_t       w_flags;
    logic [WIDTH-1:0] w_diff;

    assign w_valid[0]      = in_valid;
    assign w_a[0]          = in_a;
    assign w_b[0]          = {1'b0, in_b};
    assign w_d[0]          = '0;
    assign w_bo[0]         = 1'b0;
    assign w_tag[0]        = in_tag;
    assign w_ready[STAGES] = out_ready;
    assign in_ready        = w_ready[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        gamma_sub_stage #(
            .W1    (W1),
            .CHUNK (CHUNK),
            .K     (k),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (w_valid[k]),
            .in_ready  (w_ready[k]),
            .in_a      (w_a[k]),
            .in_b      (w_b[k]),
            .in_d      (w_d[k]),
            .in_bo     (w_bo[k]),
            .in_tag    (w_tag[k]),
            .out_valid (w_valid[k+1]),
            .out_ready (w_ready[k+1]),
            .out_a     (w_a[k+1]),
            .out_b     (w_b[k+1]),
            .out_d     (w_d[k+1]),
            .out_bo    (w_bo[k+1]),
            .out_tag   (w_tag[k+1])
        );
    end

    // operands are fully consumed by the last slice
    assign w_unused = ^{w_a[STAGES], w_b[STAGES]};

    assign w_flags.carry  = w_d[STAGES][WIDTH];
    assign w_flags.borrow = w_bo[STAGES];

`ifdef SUB_SATURATE_EN
    always_comb begin
        w_diff = w_d[STAGES][WIDTH-1:0];
        if (w_flags.borrow) begin
            w_diff = '0;
        end else if (w_flags.carry) begin
            w_diff = '1;
        end
    end
`else
    assign w_diff = w_d[STAGES][WIDTH-1:0];
`endif

    assign out_valid  = w_valid[STAGES];
    assign out_diff   = w_diff;
    assign out_carry  = w_flags.carry;
    assign out_borrow = w_flags.borrow;
    assign out_tag    = w_tag[STAGES];

endmodule

// File: tb/tb_gamma_sub_pipe.sv
// Bench for gamma_sub_pipe: directed WIDTH=8 cases plus a random
// WIDTH=16/CHUNK=5 stream scored against an arithmetic model.
module tb_gamma_sub_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic        i8_valid, i8_ready, o8_valid, o8_ready;
    logic [8:0]  i8_a;
    logic [7:0]  i8_b, o8_diff;
    logic [3:0]  i8_tag, o8_tag;
    logic        o8_carry, o8_borrow;

    logic        i16_valid, i16_ready, o16_valid, o16_ready;
    logic [16:0] i16_a;
    logic [15:0] i16_b, o16_diff;
    logic [7:0]  i16_tag, o16_tag;
    logic        o16_carry, o16_borrow;

    gamma_sub_pipe #(.WIDTH(8), .CHUNK(4), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i8_valid), .in_ready(i8_ready),
        .in_a(i8_a), .in_b(i8_b), .in_tag(i8_tag),
        .out_valid(o8_valid), .out_ready(o8_ready),
        .out_diff(o8_diff), .out_carry(o8_carry),
        .out_borrow(o8_borrow), .out_tag(o8_tag)
    );

    gamma_sub_pipe #(.WIDTH(16), .CHUNK(5), .TAG_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i16_valid), .in_ready(i16_ready),
        .in_a(i16_a), .in_b(i16_b), .in_tag(i16_tag),
        .out_valid(o16_valid), .out_ready(o16_ready),
        .out_diff(o16_diff), .out_carry(o16_carry),
        .out_borrow(o16_borrow), .out_tag(o16_tag)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {borrow, carry, diff} from plain modular arithmetic
    function automatic logic [63:0] model(input int w,
                                          input longint unsigned a,
                                          input longint unsigned b);
        longint unsigned m1, dm, diff, cy, bo;
        m1   = 64'd1 << (w + 1);
        dm   = (a + m1 - b) % m1;
        bo   = (a < b) ? 64'd1 : 64'd0;
        cy   = (dm >> w) & 64'd1;
        diff = dm % (m1 >> 1);
`ifdef SUB_SATURATE_EN
        if (bo != 0) diff = 0;
        else if (cy != 0) diff = (m1 >> 1) - 1;
`endif
        return diff | (cy << w) | (bo << (w + 1));
    endfunction

    function automatic logic [63:0] res8();
        return 64'({o8_borrow, o8_carry, o8_diff});
    endfunction

    function automatic logic [63:0] res16();
        return 64'({o16_tag, o16_borrow, o16_carry, o16_diff});
    endfunction

    task automatic one8(input string nm, input int a, input int b,
                        input int tg, input logic [63:0] exp);
        int n;
        @(negedge clk);
        i8_valid = 1'b1;
        i8_a = 9'(a);
        i8_b = 8'(b);
        i8_tag = 4'(tg);
        o8_ready = 1'b1;
        #1;
        chk({nm, "_rdy"}, 64'(i8_ready), 1);
        @(negedge clk);
        i8_valid = 1'b0;
        n = 1;
        #1;
        while (!o8_valid && n < 10) begin
            @(negedge clk);
            n++;
            #1;
        end
        chk({nm, "_lat"}, n, 3);
        chk({nm, "_res"}, res8(), exp);
        chk({nm, "_tag"}, 64'(o8_tag), tg);
    endtask

    initial begin
        int sent, got, gaps, cyc, seen, acc;
        logic [63:0] hold, cur;
        logic [63:0] q[$];
        logic hold_v;

        i8_valid = 0; i8_a = '0; i8_b = '0; i8_tag = '0; o8_ready = 0;
        i16_valid = 0; i16_a = '0; i16_b = '0; i16_tag = '0; o16_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(o8_valid), 0);
        chk("rst_res", res8(), 0);
        chk("rst_tag", 64'(o8_tag), 0);
        chk("rst_ready", 64'(i8_ready), 1);
        chk("rst16_valid", 64'({o16_valid, res16()}), 0);
        rst_n = 1'b1;

        one8("eq", 32, 32, 3, 64'h000);
`ifdef SUB_SATURATE_EN
        one8("ovf", 300, 20, 9, 64'h1FF);
        one8("neg", 5, 7, 12, 64'h300);
        one8("wrap", 0, 255, 5, 64'h300);
`else
        one8("ovf", 300, 20, 9, 64'h118);
        one8("neg", 5, 7, 12, 64'h3FE);
        one8("wrap", 0, 255, 5, 64'h301);
`endif

        // backpressure: 5 beats against a stalled consumer
        @(negedge clk);
        o8_ready = 1'b0;
        sent = 0;
        hold = '0;
        for (int c = 0; c < 6; c++) begin
            i8_valid = (sent < 5);
            i8_tag = 4'(sent + 1);
            i8_a = 9'(100 + 10 * (sent + 1));
            i8_b = 8'(sent + 1);
            #1;
            if (i8_valid && i8_ready) sent++;
            cur = 64'({o8_valid, o8_tag, res8()[9:0]});
            if (c == 3) hold = cur;
            if (c > 3) chk("bp_hold", cur, hold);
            @(negedge clk);
        end
        #1;
        chk("bp_accepted", sent, 3);
        chk("bp_in_ready", 64'(i8_ready), 0);
        chk("bp_valid", 64'(o8_valid), 1);
        o8_ready = 1'b1;
        got = 0;
        gaps = 0;
        cyc = 0;
        while (got < 5 && cyc < 40) begin
            i8_valid = (sent < 5);
            i8_tag = 4'(sent + 1);
            i8_a = 9'(100 + 10 * (sent + 1));
            i8_b = 8'(sent + 1);
            #1;
            if (i8_valid && i8_ready) sent++;
            if (o8_valid) begin
                chk("bp_tag", 64'(o8_tag), got + 1);
                chk("bp_res", res8(), model(8, 100 + 10 * (got + 1), got + 1));
                got++;
            end else if (got > 0) begin
                gaps++;
            end
            @(negedge clk);
            cyc++;
        end
        i8_valid = 1'b0;
        chk("bp_count", got, 5);
        chk("bp_gaps", gaps, 0);

        // reset with two beats in flight
        o8_ready = 1'b0;
        i8_valid = 1'b1; i8_a = 9'd200; i8_b = 8'd50; i8_tag = 4'd6;
        @(negedge clk);
        i8_a = 9'd9; i8_b = 8'd3; i8_tag = 4'd7;
        @(negedge clk);
        i8_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_pre_valid", 64'(o8_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", 64'(o8_valid), 0);
        chk("mid_res", res8(), 0);
        chk("mid_tag", 64'(o8_tag), 0);
        chk("mid_ready", 64'(i8_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        o8_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            #1;
            if (o8_valid) seen++;
            @(negedge clk);
        end
        chk("mid_ghost", seen, 0);
        chk("mid_ready_after", 64'(i8_ready), 1);

        // random stream on the 16-bit instance
        acc = 0;
        cyc = 0;
        hold_v = 1'b0;
        while (acc < 2000 && cyc < 30000) begin
            i16_valid = ($urandom_range(0, 9) < 7);
            i16_a = 17'($urandom);
            i16_b = 16'($urandom);
            i16_tag = 8'($urandom);
            case ($urandom_range(0, 15))
                0: begin i16_a = '0; i16_b = 16'hFFFF; end
                1: i16_b = i16_a[15:0];
                2: i16_a = 17'h1FFFF;
                default: ;
            endcase
            o16_ready = ($urandom_range(0, 9) < 7);
            #1;
            cur = res16();
            if (hold_v) chk("rnd_hold", 64'({o16_valid, cur[25:0]}), hold);
            if (o16_valid && o16_ready) begin
                chk("rnd_qsize", 64'(q.size() != 0), 1);
                if (q.size() != 0) chk("rnd_out", cur, q.pop_front());
            end
            if (i16_valid && i16_ready) begin
                q.push_back((64'(i16_tag) << 18) | model(16, i16_a, i16_b));
                acc++;
            end
            hold_v = o16_valid && !o16_ready;
            hold = 64'({1'b1, cur[25:0]});
            @(negedge clk);
            cyc++;
        end
        i16_valid = 1'b0;
        o16_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            #1;
            if (o16_valid) chk("rnd_drain_out", res16(), q.pop_front());
            @(negedge clk);
            cyc++;
        end
        chk("rnd_count", acc, 2000);
        chk("rnd_drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
